// File: rtl/pcpu_fwd_if.sv
// Instruction-ROM and data-RAM bus between the pcpu_fwd core (master) and board memories (slave).
interface pcpu_fwd_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] i_addr;
  logic [15:0]       i_datain;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_datain;
  logic [DATA_W-1:0] d_dataout;
  logic              d_we;

  modport master (output i_addr, d_addr, d_dataout, d_we, input i_datain, d_datain);
  modport slave  (input i_addr, d_addr, d_dataout, d_we, output i_datain, d_datain);
endinterface

// File: rtl/pcpu_fwd.sv
// Five-stage pipelined CPU with full forwarding, load-use stall, branch flush and perf counters.
// state  | meaning
// S_IDLE | pipeline, GRs, flags and counters hold
// S_EXEC | pipeline advances every cycle
module pcpu_fwd #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              start,
  pcpu_fwd_if.master        bus,
  input  logic [3:0]        select_y,
  input  logic              show_gr,
  output logic [DATA_W-1:0] y
);
  localparam logic [4:0] OP_NOP  = 5'd0,  OP_HALT = 5'd1,  OP_LOAD = 5'd2,  OP_STORE = 5'd3;
  localparam logic [4:0] OP_SL   = 5'd4,  OP_SRL  = 5'd6,  OP_SRA  = 5'd7;
  localparam logic [4:0] OP_ADD  = 5'd8,  OP_ADDI = 5'd9,  OP_SUB  = 5'd10, OP_SUBI  = 5'd11;
  localparam logic [4:0] OP_CMP  = 5'd12, OP_AND  = 5'd13, OP_OR   = 5'd14, OP_XOR   = 5'd15;
  localparam logic [4:0] OP_LDIH = 5'd16, OP_ADDC = 5'd17, OP_SUBC = 5'd18, OP_MOV   = 5'd19;
  localparam logic [4:0] OP_NOT  = 5'd20, OP_JUMP = 5'd24, OP_JMPR = 5'd25, OP_BZ    = 5'd26;
  localparam logic [4:0] OP_BNZ  = 5'd27, OP_BN   = 5'd28, OP_BNN  = 5'd29, OP_BC    = 5'd30;
  localparam logic [4:0] OP_BNC  = 5'd31;

  typedef enum logic {S_IDLE, S_EXEC} state_t;
  state_t state_q, state_d;

  logic [ADDR_W-1:0] pc;
  logic [15:0]       id_ir, ex_ir, mem_ir, wb_ir;
  logic [DATA_W-1:0] reg_a, reg_b, reg_c, reg_c1, smdr, smdr1;
  logic              zf, nf, cf;
  logic [DATA_W-1:0] gr [8];
  logic [CNT_W-1:0]  retired_cnt, stall_cnt;

  logic [4:0]        id_op, ex_op, mem_op, wb_op;
  logic              run, stall, taken, wb_halt;
  logic              ex_fwd, mem_fwd, wb_fwd;
  logic [DATA_W-1:0] mem_val, alu_out, imm_b;
  logic              alu_cf, a_use, b_use, s_use;
  logic [DATA_W:0]   sum;
  logic [2:0]        a_idx, b_idx;
  logic [2:0]        rd_idx [3];
  logic [DATA_W-1:0] rd_val [3];

  function automatic logic writes_gr(input logic [4:0] op);
    case (op)
      OP_LOAD, OP_MOV, OP_ADD, OP_ADDI, OP_ADDC, OP_SUB, OP_SUBI, OP_SUBC,
      OP_NOT, OP_AND, OP_OR, OP_XOR, OP_SL, OP_SRL, OP_SRA, OP_LDIH: writes_gr = 1'b1;
      default: writes_gr = 1'b0;
    endcase
  endfunction

  assign id_op   = id_ir[15:11];
  assign ex_op   = ex_ir[15:11];
  assign mem_op  = mem_ir[15:11];
  assign wb_op   = wb_ir[15:11];
  assign wb_halt = (wb_op == OP_HALT);
  assign ex_fwd  = writes_gr(ex_op) && (ex_op != OP_LOAD);
  assign mem_fwd = writes_gr(mem_op);
  assign wb_fwd  = writes_gr(wb_op);
  assign mem_val = (mem_op == OP_LOAD) ? bus.d_datain : reg_c;

  assign bus.i_addr    = pc;
  assign bus.d_addr    = reg_c[ADDR_W-1:0];
  assign bus.d_dataout = smdr1;
  assign bus.d_we      = (mem_op == OP_STORE);

  always_ff @(posedge clock) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    run     = 1'b0;
    case (state_q)
      S_IDLE: if (enable && start) state_d = S_EXEC;
      S_EXEC: if (!enable || wb_halt) state_d = S_IDLE;
              else run = 1'b1;
      default: state_d = S_IDLE;
    endcase
  end

  // Operand selection: A from r2 (or r1 for accumulate/branch forms), B from r3 or an immediate.
  always_comb begin
    a_idx = id_ir[6:4];
    b_idx = id_ir[2:0];
    a_use = 1'b0;
    b_use = 1'b0;
    s_use = 1'b0;
    imm_b = '0;
    case (id_op)
      OP_LOAD:  begin a_use = 1'b1; imm_b = DATA_W'(id_ir[3:0]); end
      OP_STORE: begin a_use = 1'b1; s_use = 1'b1; imm_b = DATA_W'(id_ir[3:0]); end
      OP_ADD, OP_ADDC, OP_SUB, OP_SUBC, OP_CMP, OP_AND, OP_OR, OP_XOR:
        begin a_use = 1'b1; b_use = 1'b1; end
      OP_ADDI, OP_SUBI: begin a_idx = id_ir[10:8]; a_use = 1'b1; imm_b = DATA_W'(id_ir[7:0]); end
      OP_LDIH:  begin a_idx = id_ir[10:8]; a_use = 1'b1; imm_b = DATA_W'({id_ir[7:0], 8'h00}); end
      OP_SL, OP_SRL, OP_SRA: begin a_use = 1'b1; imm_b = DATA_W'(id_ir[3:0]); end
      OP_NOT:   a_use = 1'b1;
      OP_MOV, OP_JUMP: imm_b = DATA_W'(id_ir[7:0]);
      OP_JMPR, OP_BZ, OP_BNZ, OP_BN, OP_BNN, OP_BC, OP_BNC:
        begin a_idx = id_ir[10:8]; a_use = 1'b1; imm_b = DATA_W'(id_ir[7:0]); end
      default: ;
    endcase
  end

  always_comb begin
    rd_idx[0] = a_idx;
    rd_idx[1] = b_idx;
    rd_idx[2] = id_ir[10:8];
    for (int k = 0; k < 3; k++) begin
      if (ex_fwd && ex_ir[10:8] == rd_idx[k])        rd_val[k] = alu_out;
      else if (mem_fwd && mem_ir[10:8] == rd_idx[k]) rd_val[k] = mem_val;
      else if (wb_fwd && wb_ir[10:8] == rd_idx[k])   rd_val[k] = reg_c1;
      else                                           rd_val[k] = gr[rd_idx[k]];
    end
  end

  assign stall = (ex_op == OP_LOAD) &&
                 ((a_use && a_idx == ex_ir[10:8]) || (b_use && b_idx == ex_ir[10:8]) ||
                  (s_use && id_ir[10:8] == ex_ir[10:8]));

  always_comb begin
    sum     = '0;
    alu_out = '0;
    alu_cf  = 1'b0;
    case (ex_op)
      OP_ADD, OP_ADDI, OP_LDIH: sum = {1'b0, reg_a} + {1'b0, reg_b};
      OP_ADDC: sum = {1'b0, reg_a} + {1'b0, reg_b} + (DATA_W+1)'(cf);
      OP_SUB, OP_SUBI, OP_CMP: sum = {1'b0, reg_a} - {1'b0, reg_b};
      OP_SUBC: sum = {1'b0, reg_a} - {1'b0, reg_b} - (DATA_W+1)'(cf);
      default: ;
    endcase
    case (ex_op)
      OP_ADD, OP_ADDI, OP_LDIH, OP_ADDC, OP_SUB, OP_SUBI, OP_CMP, OP_SUBC:
        begin alu_out = sum[DATA_W-1:0]; alu_cf = sum[DATA_W]; end
      OP_AND:  alu_out = reg_a & reg_b;
      OP_OR:   alu_out = reg_a | reg_b;
      OP_XOR:  alu_out = reg_a ^ reg_b;
      OP_NOT:  alu_out = ~reg_a;
      OP_SL:   alu_out = reg_a << reg_b[3:0];
      OP_SRL:  alu_out = reg_a >> reg_b[3:0];
      OP_SRA:  alu_out = DATA_W'($signed(reg_a) >>> reg_b[3:0]);
      default: alu_out = reg_a + reg_b;
    endcase
  end

  always_comb begin
    case (mem_op)
      OP_JUMP, OP_JMPR: taken = 1'b1;
      OP_BZ:   taken = zf;
      OP_BNZ:  taken = !zf;
      OP_BN:   taken = nf;
      OP_BNN:  taken = !nf;
      OP_BC:   taken = cf;
      OP_BNC:  taken = !cf;
      default: taken = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pc <= '0;
      id_ir <= '0; ex_ir <= '0; mem_ir <= '0; wb_ir <= '0;
      reg_a <= '0; reg_b <= '0; reg_c <= '0; reg_c1 <= '0; smdr <= '0; smdr1 <= '0;
      zf <= 1'b0; nf <= 1'b0; cf <= 1'b0;
      retired_cnt <= '0; stall_cnt <= '0;
      for (int i = 0; i < 8; i++) gr[i] <= '0;
    end else if (run) begin
      wb_ir  <= mem_ir;
      reg_c1 <= mem_val;
      if (wb_fwd) gr[wb_ir[10:8]] <= reg_c1;
      if (wb_op != OP_NOP) retired_cnt <= retired_cnt + CNT_W'(1);
      reg_c <= alu_out;
      smdr1 <= smdr;
      reg_a <= a_use ? rd_val[0] : '0;
      reg_b <= b_use ? rd_val[1] : imm_b;
      smdr  <= rd_val[2];
      // A taken branch kills the three younger slots, including any pending stall.
      if (taken) begin
        pc     <= reg_c[ADDR_W-1:0];
        id_ir  <= '0;
        ex_ir  <= '0;
        mem_ir <= '0;
      end else begin
        mem_ir <= ex_ir;
        if (ex_op != OP_NOP && ex_op[4:3] != 2'b11) begin
          zf <= (alu_out == '0);
          nf <= alu_out[DATA_W-1];
          cf <= alu_cf;
        end
        if (stall) begin
          ex_ir     <= '0;
          stall_cnt <= stall_cnt + CNT_W'(1);
        end else begin
          pc    <= pc + ADDR_W'(1);
          id_ir <= bus.i_datain;
          ex_ir <= id_ir;
        end
      end
    end
  end

  always_comb begin
    y = '0;
    if (show_gr) y = gr[select_y[2:0]];
    else begin
      case (select_y)
        4'd0, 4'd15: y = DATA_W'(pc);
        4'd1:  y = DATA_W'(id_ir);
        4'd2:  y = DATA_W'(ex_ir);
        4'd3:  y = DATA_W'(mem_ir);
        4'd4:  y = DATA_W'(wb_ir);
        4'd5:  y = reg_a;
        4'd6:  y = reg_b;
        4'd7:  y = reg_c;
        4'd8:  y = DATA_W'({zf, nf, cf});
        4'd9:  y = DATA_W'(bus.d_we);
        4'd10: y = smdr;
        4'd11: y = smdr1;
        4'd12: y = reg_c1;
        4'd13: y = DATA_W'(retired_cnt);
        default: y = DATA_W'(stall_cnt);
      endcase
    end
  end
endmodule

// File: tb/tb_pcpu_fwd.sv
// Directed bench for pcpu_fwd (32-bit datapath) with behavioural ROM/RAM on the memory interface.
module tb_pcpu_fwd;
  localparam logic [4:0] NOP = 5'd0, HALT = 5'd1, LOAD = 5'd2, STORE = 5'd3, ADD = 5'd8;
  localparam logic [4:0] ADDI = 5'd9, SUB = 5'd10, LDIH = 5'd16, MOV = 5'd19, JUMP = 5'd24, BZ = 5'd26;

  logic        clock = 1'b0, reset_n = 1'b0, enable = 1'b0, start = 1'b0, show_gr = 1'b0;
  logic [3:0]  select_y = 4'd0;
  logic [31:0] y, v;
  logic [15:0] rom [256];
  logic [31:0] ram [256];
  int          n_checks = 0, n_fail = 0;

  pcpu_fwd_if #(.DATA_W(32), .ADDR_W(8)) bus ();

  pcpu_fwd #(.DATA_W(32), .ADDR_W(8), .CNT_W(16)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .start(start),
    .bus(bus), .select_y(select_y), .show_gr(show_gr), .y(y)
  );

  always #10 clock = ~clock;

  assign bus.i_datain = rom[bus.i_addr];
  assign bus.d_datain = ram[bus.d_addr];

  always @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < 256; i++) ram[i] <= 32'h0;
      ram[4] <= 32'h0000_0077;
    end else if (bus.d_we) ram[bus.d_addr] <= bus.d_dataout;
  end

  function automatic logic [15:0] ri(input logic [4:0] op, input logic [2:0] r1, input logic [7:0] imm);
    return {op, r1, imm};
  endfunction

  function automatic logic [15:0] rr(input logic [4:0] op, input logic [2:0] r1, input logic [2:0] r2,
                                     input logic [3:0] v3);
    return {op, r1, 1'b0, r2, v3};
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic peek(input logic g, input logic [3:0] s, output logic [31:0] val);
    show_gr = g;
    select_y = s;
    #1;
    val = y;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    enable = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = 16'h0;
    step(2);
    reset_n = 1'b1;
  endtask

  // After return the core is in EXEC cycle 0 (pc = 0 being fetched).
  task automatic go();
    enable = 1'b1;
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int s = 0; s < 16; s++) begin
      peek(1'b0, 4'(s), v); n_checks++;
      if (v !== 32'h0) begin n_fail++; $display("FAIL reset_sel%0d: got %h want 0", s, v); end
    end
    for (int r = 0; r < 8; r++) begin
      peek(1'b1, 4'(r), v); n_checks++;
      if (v !== 32'h0) begin n_fail++; $display("FAIL reset_gr%0d: got %h want 0", r, v); end
    end
    start = 1'b1;
    step(3);
    start = 1'b0;
    peek(1'b0, 4'd0, v); n_checks++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL start_no_enable_pc: got %h want 0", v); end
  endtask

  task automatic test_forward_chain();
    do_reset();
    rom[0] = ri(MOV, 3'd1, 8'd5);
    rom[1] = ri(ADDI, 3'd1, 8'd3);
    rom[2] = rr(ADD, 3'd2, 3'd1, 4'd1);
    go();
    step(10);
    peek(1'b1, 4'd1, v); n_checks++;
    if (v !== 32'd8) begin n_fail++; $display("FAIL chain_r1: got %h want 8", v); end
    peek(1'b1, 4'd2, v); n_checks++;
    if (v !== 32'd16) begin n_fail++; $display("FAIL chain_r2: got %h want 16", v); end
    peek(1'b0, 4'd14, v); n_checks++;
    if (v !== 32'd0) begin n_fail++; $display("FAIL chain_stall_cnt: got %0d want 0", v); end
    peek(1'b0, 4'd13, v); n_checks++;
    if (v !== 32'd3) begin n_fail++; $display("FAIL chain_retired_cnt: got %0d want 3", v); end
  endtask

  task automatic test_fwd_distance();
    do_reset();
    rom[0] = ri(MOV, 3'd1, 8'd5);
    rom[1] = ri(MOV, 3'd2, 8'd9);
    rom[3] = rr(ADD, 3'd3, 3'd1, 4'd2);
    go();
    step(10);
    peek(1'b1, 4'd3, v); n_checks++;
    if (v !== 32'd14) begin n_fail++; $display("FAIL wb_mem_fwd_r3: got %h want 14", v); end
  endtask

  task automatic test_load_use();
    do_reset();
    rom[0] = rr(LOAD, 3'd3, 3'd0, 4'd4);
    rom[1] = rr(ADD, 3'd4, 3'd3, 4'd3);
    go();
    step(2);
    peek(1'b0, 4'd2, v); n_checks++;
    if (v !== 32'(rom[0])) begin n_fail++; $display("FAIL lu_ex_load: got %h want %h", v, rom[0]); end
    step(1);
    peek(1'b0, 4'd2, v); n_checks++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL lu_ex_bubble: got %h want 0", v); end
    peek(1'b0, 4'd3, v); n_checks++;
    if (v !== 32'(rom[0])) begin n_fail++; $display("FAIL lu_mem_load: got %h want %h", v, rom[0]); end
    peek(1'b0, 4'd1, v); n_checks++;
    if (v !== 32'(rom[1])) begin n_fail++; $display("FAIL lu_id_held: got %h want %h", v, rom[1]); end
    peek(1'b0, 4'd0, v); n_checks++;
    if (v !== 32'd2) begin n_fail++; $display("FAIL lu_pc_held: got %h want 2", v); end
    step(1);
    peek(1'b0, 4'd2, v); n_checks++;
    if (v !== 32'(rom[1])) begin n_fail++; $display("FAIL lu_ex_add: got %h want %h", v, rom[1]); end
    step(8);
    peek(1'b1, 4'd3, v); n_checks++;
    if (v !== 32'h77) begin n_fail++; $display("FAIL lu_r3: got %h want 77", v); end
    peek(1'b1, 4'd4, v); n_checks++;
    if (v !== 32'hEE) begin n_fail++; $display("FAIL lu_r4: got %h want ee", v); end
    peek(1'b0, 4'd14, v); n_checks++;
    if (v !== 32'd1) begin n_fail++; $display("FAIL lu_stall_cnt: got %0d want 1", v); end
    peek(1'b0, 4'd13, v); n_checks++;
    if (v !== 32'd2) begin n_fail++; $display("FAIL lu_retired_cnt: got %0d want 2", v); end
  endtask

  task automatic test_branch_flush();
    do_reset();
    rom[0] = rr(SUB, 3'd5, 3'd5, 4'd5);
    rom[1] = ri(BZ, 3'd0, 8'd10);
    rom[2] = ri(MOV, 3'd6, 8'd1);
    rom[3] = ri(MOV, 3'd6, 8'd1);
    rom[4] = ri(MOV, 3'd6, 8'd1);
    rom[10] = ri(MOV, 3'd7, 8'd2);
    go();
    step(4);
    peek(1'b0, 4'd3, v); n_checks++;
    if (v !== 32'(rom[1])) begin n_fail++; $display("FAIL br_mem_bz: got %h want %h", v, rom[1]); end
    peek(1'b0, 4'd8, v); n_checks++;
    if (v !== 32'h4) begin n_fail++; $display("FAIL br_flags_zf: got %h want 4", v); end
    step(1);
    peek(1'b0, 4'd0, v); n_checks++;
    if (v !== 32'd10) begin n_fail++; $display("FAIL br_pc_target: got %0d want 10", v); end
    for (int s = 1; s < 4; s++) begin
      peek(1'b0, 4'(s), v); n_checks++;
      if (v !== 32'h0) begin n_fail++; $display("FAIL br_flush_sel%0d: got %h want 0", s, v); end
    end
    step(8);
    peek(1'b1, 4'd6, v); n_checks++;
    if (v !== 32'd0) begin n_fail++; $display("FAIL br_r6: got %h want 0", v); end
    peek(1'b1, 4'd7, v); n_checks++;
    if (v !== 32'd2) begin n_fail++; $display("FAIL br_r7: got %h want 2", v); end
    peek(1'b0, 4'd13, v); n_checks++;
    if (v !== 32'd3) begin n_fail++; $display("FAIL br_retired_cnt: got %0d want 3", v); end
  endtask

  task automatic test_store();
    int we_cnt, we_cyc;
    logic [7:0]  we_addr;
    logic [31:0] we_data, pc5;
    do_reset();
    rom[0] = ri(ADDI, 3'd1, 8'h55);
    rom[1] = rr(STORE, 3'd1, 3'd0, 4'd9);
    go();
    we_cnt = 0; we_cyc = -1; we_addr = '0; we_data = '0;
    for (int c = 0; c < 12; c++) begin
      if (bus.d_we === 1'b1) begin
        we_cnt++; we_cyc = c; we_addr = bus.d_addr; we_data = bus.d_dataout;
      end
      step(1);
    end
    n_checks++;
    if (we_cnt != 1) begin n_fail++; $display("FAIL st_we_count: got %0d want 1", we_cnt); end
    n_checks++;
    if (we_cyc != 4) begin n_fail++; $display("FAIL st_we_cycle: got %0d want 4", we_cyc); end
    n_checks++;
    if (we_addr !== 8'd9) begin n_fail++; $display("FAIL st_addr: got %0d want 9", we_addr); end
    n_checks++;
    if (we_data !== 32'h55) begin n_fail++; $display("FAIL st_data: got %h want 55", we_data); end
    n_checks++;
    if (ram[9] !== 32'h55) begin n_fail++; $display("FAIL st_ram9: got %h want 55", ram[9]); end

    do_reset();
    rom[0] = ri(ADDI, 3'd1, 8'h33);
    rom[1] = ri(JUMP, 3'd0, 8'd20);
    rom[2] = rr(STORE, 3'd1, 3'd0, 4'd12);
    go();
    we_cnt = 0; pc5 = '1;
    for (int c = 0; c < 12; c++) begin
      if (bus.d_we === 1'b1) we_cnt++;
      if (c == 5) peek(1'b0, 4'd0, pc5);
      step(1);
    end
    n_checks++;
    if (we_cnt != 0) begin n_fail++; $display("FAIL st_flushed_we: got %0d want 0", we_cnt); end
    n_checks++;
    if (ram[12] !== 32'h0) begin n_fail++; $display("FAIL st_flushed_ram: got %h want 0", ram[12]); end
    n_checks++;
    if (pc5 !== 32'd20) begin n_fail++; $display("FAIL jump_pc: got %0d want 20", pc5); end
  endtask

  task automatic test_wide();
    do_reset();
    rom[0] = ri(LDIH, 3'd2, 8'h12);
    rom[1] = ri(ADDI, 3'd2, 8'h34);
    rom[2] = ri(MOV, 3'd1, 8'd1);
    rom[3] = rr(SUB, 3'd3, 3'd0, 4'd1);
    go();
    step(10);
    peek(1'b1, 4'd2, v); n_checks++;
    if (v !== 32'h0000_1234) begin n_fail++; $display("FAIL wide_r2: got %h want 00001234", v); end
    peek(1'b1, 4'd3, v); n_checks++;
    if (v !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wide_r3: got %h want ffffffff", v); end
    peek(1'b0, 4'd8, v); n_checks++;
    if (v !== 32'h3) begin n_fail++; $display("FAIL wide_flags: got %h want 3 (nf,cf)", v); end
  endtask

  task automatic test_reset_midrun();
    do_reset();
    rom[0] = rr(LOAD, 3'd3, 3'd0, 4'd4);
    rom[1] = rr(ADD, 3'd4, 3'd3, 4'd3);
    go();
    step(2);
    reset_n = 1'b0;
    step(1);
    for (int s = 0; s < 16; s++) begin
      peek(1'b0, 4'(s), v); n_checks++;
      if (v !== 32'h0) begin n_fail++; $display("FAIL midrst_sel%0d: got %h want 0", s, v); end
    end
    n_checks++;
    if (bus.d_we !== 1'b0) begin n_fail++; $display("FAIL midrst_d_we: got %b want 0", bus.d_we); end
    reset_n = 1'b1;
    step(3);
    peek(1'b0, 4'd0, v); n_checks++;
    if (v !== 32'h0) begin n_fail++; $display("FAIL midrst_idle_pc: got %h want 0", v); end
  endtask

  task automatic test_enable_drop();
    do_reset();
    rom[0] = ri(MOV, 3'd1, 8'd5);
    rom[1] = ri(ADDI, 3'd1, 8'd3);
    rom[2] = rr(ADD, 3'd2, 3'd1, 4'd1);
    go();
    step(2);
    enable = 1'b0;
    step(6);
    peek(1'b0, 4'd0, v); n_checks++;
    if (v !== 32'd2) begin n_fail++; $display("FAIL en_pc_frozen: got %0d want 2", v); end
    peek(1'b0, 4'd1, v); n_checks++;
    if (v !== 32'(rom[1])) begin n_fail++; $display("FAIL en_id_frozen: got %h want %h", v, rom[1]); end
    peek(1'b0, 4'd2, v); n_checks++;
    if (v !== 32'(rom[0])) begin n_fail++; $display("FAIL en_ex_frozen: got %h want %h", v, rom[0]); end
    go();
    step(10);
    peek(1'b1, 4'd2, v); n_checks++;
    if (v !== 32'd16) begin n_fail++; $display("FAIL en_resume_r2: got %h want 16", v); end
  endtask

  task automatic test_halt();
    do_reset();
    rom[0] = ri(MOV, 3'd1, 8'd7);
    rom[1] = ri(HALT, 3'd0, 8'd0);
    rom[2] = ri(MOV, 3'd1, 8'd9);
    go();
    step(5);
    peek(1'b0, 4'd4, v); n_checks++;
    if (v !== 32'(rom[1])) begin n_fail++; $display("FAIL halt_wb: got %h want %h", v, rom[1]); end
    peek(1'b0, 4'd0, v); n_checks++;
    if (v !== 32'd5) begin n_fail++; $display("FAIL halt_pc_at_wb: got %0d want 5", v); end
    step(6);
    peek(1'b0, 4'd0, v); n_checks++;
    if (v !== 32'd5) begin n_fail++; $display("FAIL halt_pc_stable: got %0d want 5", v); end
    peek(1'b0, 4'd4, v); n_checks++;
    if (v !== 32'(rom[1])) begin n_fail++; $display("FAIL halt_wb_stable: got %h want %h", v, rom[1]); end
    peek(1'b1, 4'd1, v); n_checks++;
    if (v !== 32'd7) begin n_fail++; $display("FAIL halt_r1: got %h want 7", v); end
    peek(1'b0, 4'd13, v); n_checks++;
    if (v !== 32'd1) begin n_fail++; $display("FAIL halt_retired_cnt: got %0d want 1", v); end
  endtask

  initial begin
    test_reset();
    test_forward_chain();
    test_fwd_distance();
    test_load_use();
    test_branch_flush();
    test_store();
    test_wide();
    test_reset_midrun();
    test_enable_drop();
    test_halt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
